// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// ----------------------------------------------------------------------------
// IF stage of the 5-stage MIPS pipeline. It owns the PC, fetches from
// instruction memory with a req/ready handshake and holds the IF/ID pipeline
// register. A one-entry skid buffer keeps a word that returns while ID is
// stalled, so no fetched instruction is lost or duplicated. An EX redirect
// (taken branch or jump) flushes IF/ID and restarts fetch at the target.
//
// Ports:
//   clk                  pipeline clock, all state on posedge
//   reset                asynchronous, active-high
//   stall_flag_if        ID scoreboard stall: hold IF/ID and PC
//   redirect_valid       EX taken branch / jump
//   redirect_target      new PC (bits [1:0] forced to 00)
//   imem_req/imem_addr   fetch request and address (address == PC)
//   imem_ready/imem_rdata  memory response, data valid when ready=1
//   inst_out             IF/ID instruction
//   pc_plus4_out         IF/ID PC+4
//   valid_out            IF/ID holds a real instruction
//   stall_flag           ~valid_out, freezes the ID datapath
//   opcode, inst_read_reg_addr1/2, rd, inst_imm_field  slices of inst_out
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_flag_if,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] pc_plus4_out,
  output logic              valid_out,
  output logic              stall_flag,
  output logic [4:0]        inst_read_reg_addr1,
  output logic [4:0]        inst_read_reg_addr2,
  output logic [4:0]        rd,
  output logic [15:0]       inst_imm_field,
  output logic [5:0]        opcode
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [31:0]       inst_q,     inst_d;
  logic [ADDR_W-1:0] pc4_q,      pc4_d;
  logic              valid_q,    valid_d;
  logic [31:0]       skid_q,     skid_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

  logic [ADDR_W-1:0] pc_next_seq;
  logic [ADDR_W-1:0] target_aligned;

  // Wraps modulo 2^ADDR_W, so 0xFFFF_FFFC + 4 fetches from 0.
  assign pc_next_seq    = pc_q + ADDR_W'(4);
  assign target_aligned = {redirect_target[ADDR_W-1:2], 2'b00};

  always_comb begin
    // NOTE: every *_d defaults to its *_q first, so paths that do not assign
    // it hold state instead of inferring a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    skid_d     = skid_q;
    skid_pc4_d = skid_pc4_q;

    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) pc_d = target_aligned;
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (redirect_valid) begin
          // Overrides stall: a wrong-path instruction in ID is flushed even
          // while ID is stalled, and a word returning now is dropped.
          pc_d    = target_aligned;
          valid_d = 1'b0;
        end else if (imem_ready && !stall_flag_if) begin
          inst_d  = imem_rdata;
          pc4_d   = pc_next_seq;
          valid_d = 1'b1;
          pc_d    = pc_next_seq;
        end else if (imem_ready) begin
          // ID cannot take the word; park it and stop requesting.
          skid_d     = imem_rdata;
          skid_pc4_d = pc_next_seq;
          pc_d       = pc_next_seq;
          state_d    = ST_HOLD;
        end else if (!stall_flag_if) begin
          valid_d = 1'b0;  // bubble into ID, inst_out left as is
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = target_aligned;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (!stall_flag_if) begin
          inst_d  = skid_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its *_d regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      skid_q     <= '0;
      skid_pc4_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
      skid_pc4_q <= skid_pc4_d;
    end
  end

  assign imem_req     = (state_q == ST_REQ);
  assign imem_addr    = pc_q;
  assign inst_out     = inst_q;
  assign pc_plus4_out = pc4_q;
  assign valid_out    = valid_q;
  assign stall_flag   = ~valid_q;

  assign opcode              = inst_q[31:26];
  assign inst_read_reg_addr1 = inst_q[25:21];
  assign inst_read_reg_addr2 = inst_q[20:16];
  assign rd                  = inst_q[15:11];
  assign inst_imm_field      = inst_q[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit. Each vector gives
// the inputs for one clock cycle and the outputs expected just after that edge.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_flag_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;
  logic        stall_flag;
  logic [4:0]  inst_read_reg_addr1;
  logic [4:0]  inst_read_reg_addr2;
  logic [4:0]  rd;
  logic [15:0] inst_imm_field;
  logic [5:0]  opcode;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_flag_if       (stall_flag_if),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ready          (imem_ready),
    .imem_rdata          (imem_rdata),
    .inst_out            (inst_out),
    .pc_plus4_out        (pc_plus4_out),
    .valid_out           (valid_out),
    .stall_flag          (stall_flag),
    .inst_read_reg_addr1 (inst_read_reg_addr1),
    .inst_read_reg_addr2 (inst_read_reg_addr2),
    .rd                  (rd),
    .inst_imm_field      (inst_imm_field),
    .opcode              (opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_addr, input logic e_req,
                               input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc4);
    check({tag, " imem_addr"},    imem_addr,           e_addr);
    check({tag, " imem_req"},     32'(imem_req),       32'(e_req));
    check({tag, " valid_out"},    32'(valid_out),      32'(e_valid));
    check({tag, " stall_flag"},   32'(stall_flag),     32'(!e_valid));
    check({tag, " inst_out"},     inst_out,            e_inst);
    check({tag, " pc_plus4_out"}, pc_plus4_out,        e_pc4);
    check({tag, " opcode"},       32'(opcode),         32'(e_inst[31:26]));
    check({tag, " rs"},           32'(inst_read_reg_addr1), 32'(e_inst[25:21]));
    check({tag, " rt"},           32'(inst_read_reg_addr2), 32'(e_inst[20:16]));
    check({tag, " rd"},           32'(rd),             32'(e_inst[15:11]));
    check({tag, " imm"},          32'(inst_imm_field), 32'(e_inst[15:0]));
  endtask

  task automatic drive(input logic stall, input logic rv, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] rdata);
    stall_flag_if   = stall;
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_ready      = rdy;
    imem_rdata      = rdata;
  endtask

  initial begin
    //            stall rv  tgt           rdy  rdata           addr          req  vld  inst            pc4
    // IDLE cycle after reset release: response ignored.
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
    // Straight-line fetch, one per cycle; valid on 2nd edge after release.
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8C01_0004, 32'h0000_0004, 1'b1, 1'b1, 32'h8C01_0004, 32'h0000_0004};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0022_1820, 32'h0000_0008, 1'b1, 1'b1, 32'h0022_1820, 32'h0000_0008};
    // Word at pc=8 returns during a 3-cycle stall -> HOLD, IF/ID frozen.
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1000_0003, 32'h0000_000C, 1'b0, 1'b1, 32'h0022_1820, 32'h0000_0008};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h5555_5555, 32'h0000_000C, 1'b0, 1'b1, 32'h0022_1820, 32'h0000_0008};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0000_000C, 1'b0, 1'b1, 32'h0022_1820, 32'h0000_0008};
    // Unstall: skid word delivered, fetch resumes at 12.
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0000_000C, 1'b1, 1'b1, 32'h1000_0003, 32'h0000_000C};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2400_0005, 32'h0000_0010, 1'b1, 1'b1, 32'h2400_0005, 32'h0000_0010};
    // Redirect together with ready at pc=0x10: data dropped.
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'hBAD0_0010, 32'h0000_0100, 1'b1, 1'b0, 32'h2400_0005, 32'h0000_0010};
    // Four cycles of imem_ready low, no stall: bubbles, pc held.
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 32'h2400_0005, 32'h0000_0010};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 32'h2400_0005, 32'h0000_0010};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 32'h2400_0005, 32'h0000_0010};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0000_0100, 1'b1, 1'b0, 32'h2400_0005, 32'h0000_0010};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8C22_0008, 32'h0000_0104, 1'b1, 1'b1, 32'h8C22_0008, 32'h0000_0104};
    // Stall fills skid, then redirect to 0x43 in HOLD: skid discarded.
    vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1111_1111, 32'h0000_0108, 1'b0, 1'b1, 32'h8C22_0008, 32'h0000_0104};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0043, 1'b0, 32'h0,        32'h0000_0040, 1'b1, 1'b0, 32'h8C22_0008, 32'h0000_0104};
    vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0043_1020, 32'h0000_0044, 1'b1, 1'b1, 32'h0043_1020, 32'h0000_0044};
    // Stall with no response holds everything; redirect still flushes.
    vecs[17] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         32'h0000_0044, 1'b1, 1'b1, 32'h0043_1020, 32'h0000_0044};
    vecs[18] = '{1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,        32'h0000_0200, 1'b1, 1'b0, 32'h0043_1020, 32'h0000_0044};
    // Jump to top of address space; PC+4 wraps to 0.
    vecs[19] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0043_1020, 32'h0000_0044};
    vecs[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h03E0_0008, 32'h0000_0000, 1'b1, 1'b1, 32'h03E0_0008, 32'h0000_0000};
    vecs[21] = '{1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0,        32'h0000_0080, 1'b1, 1'b0, 32'h03E0_0008, 32'h0000_0000};

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 check_outputs("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].tgt, vecs[i].rdy, vecs[i].rdata);
      @(posedge clk);
      #1 check_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_req,
                       vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc4);
      @(negedge clk);
    end

    // Asynchronous reset while waiting on memory at 0x80: outputs clear
    // before any clock edge, and a response during reset is ignored.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1 check_outputs("async_reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    @(posedge clk);
    #1 check_outputs("reset_held", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Release again: IDLE, then first word valid on the 2nd edge.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hAC64_0010);
    @(posedge clk);
    #1 check_outputs("rerelease_idle", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 check_outputs("rerelease_first", 32'h4, 1'b1, 1'b1, 32'hAC64_0010, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the instruction decoder.
- Owns the PC and runs a request/ready handshake with instruction memory.
- Holds the IF/ID pipeline register and presents pre-split fields (rs, rt, rd, imm) to ID.
- Obeys the ID scoreboard stall (stall_flag_if) and the EX branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  pipeline clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall_flag_if  in  1  from ID scoreboard; 1 = hold IF/ID and PC.
- redirect_valid  in  1  from EX; taken branch or jump.
- redirect_target  in  ADDR_W  new PC; bits [1:0] ignored and forced to 00.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address, equal to the PC.
- imem_ready  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- inst_out  out  32  IF/ID instruction.
- pc_plus4_out  out  ADDR_W  IF/ID PC+4.
- valid_out  out  1  IF/ID holds a real instruction.
- stall_flag  out  1  equals ~valid_out; freezes ID register file, sign-extend and imm paths.
- inst_read_reg_addr1  out  5  inst_out[25:21].
- inst_read_reg_addr2  out  5  inst_out[20:16].
- rd  out  5  inst_out[15:11].
- inst_imm_field  out  16  inst_out[15:0].
- opcode  out  6  inst_out[31:26].

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - inst_out=0, pc_plus4_out=0, valid_out=0, stall_flag=1.
  - imem_req=0, skid buffer empty.
- Field outputs are purely combinational slices of inst_out.
- imem_addr=pc, combinational.
- imem_req=1 only in state REQ.
- State IDLE: one cycle after reset deasserts, then go to REQ. Redirect in IDLE: load pc=target, go to REQ.
- State REQ, evaluated in priority order:
  1. redirect_valid=1: pc<=target&~3; valid_out<=0; any imem_ready in this cycle is discarded; stay in REQ. Redirect overrides stall, so a wrong-path ID instruction is flushed even while stalled.
  2. imem_ready=1 and stall_flag_if=0: inst_out<=imem_rdata; pc_plus4_out<=pc+4; valid_out<=1; pc<=pc+4; stay in REQ.
  3. imem_ready=1 and stall_flag_if=1: skid<=imem_rdata; skid_pc4<=pc+4; pc<=pc+4; IF/ID unchanged; go to HOLD.
  4. imem_ready=0 and stall_flag_if=0: valid_out<=0 (bubble into ID); inst_out unchanged.
  5. imem_ready=0 and stall_flag_if=1: everything holds.
- State HOLD (imem_req=0):
  - redirect_valid=1: drop skid; pc<=target; valid_out<=0; go to REQ.
  - Else stall_flag_if=0: inst_out<=skid; pc_plus4_out<=skid_pc4; valid_out<=1; go to REQ.
  - Else hold.
- Latency:
  - With imem_ready held high and no stall, one instruction per cycle.
  - The first valid_out rises 2 cycles after reset release, assuming imem_ready=1 from the first request.
- Arithmetic: pc+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- Reset mid-operation: state returns to IDLE and the in-flight memory response is ignored. The memory must tolerate a withdrawn imem_req.
- No instruction is lost or duplicated across stall/unstall. Every returned word reaches IF/ID exactly once unless flushed by a redirect.

Test Plan:
- Reset, then imem_ready=1 with rdata = 0x8C01_0004, 0x0022_1820, 0x1000_0003 -> imem_addr 0,4,8; valid_out rises on the 2nd edge after reset release; inst_out follows in order; pc_plus4_out=4,8,12; rs/rt/rd of 0x0022_1820 are 1/2/3.
- Hold stall_flag_if=1 for 3 cycles while a word returns at pc=8 -> state HOLD, imem_req=0, inst_out keeps the pc=4 word. On unstall, inst_out=word@8, then imem_addr=12. No duplicate, no skip.
- redirect_valid=1 with target 0x0000_0043 during a stall -> next imem_addr=0x40, valid_out=0, stall_flag=1, and the skid content is discarded.
- redirect_valid and imem_ready together at pc=0x10 -> data dropped, imem_addr=target, no valid_out pulse for 0x10.
- imem_ready low for 4 cycles with stall_flag_if=0 -> valid_out=0 and stall_flag=1 for those cycles; pc held at its value.
- pc=0xFFFF_FFFC fetch -> pc_plus4_out=0, next imem_addr=0. Assert reset mid-wait -> outputs return to reset values immediately, without waiting for a clock edge.
